// File: rtl/seven_seg_capture.sv
// seven_seg_capture: watches a multiplexed active-low seven-segment bus,
// waits for each (anode, segment) pair to settle and decodes it back into a
// 4-bit code stored per digit position.
// Optional: define SEVEN_SEG_CAPTURE_ERRCNT_EN to enable the saturating
// pattern error counter; otherwise err_count is tied to zero.
module seven_seg_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  output logic [15:0] digits,
  output logic [3:0]  valid,
  output logic [3:0]  blank,
  output logic        update,
  output logic [1:0]  update_idx,
  output logic        pattern_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);
  localparam bit         SINGLE_SHOT  = (STABLE_CYCLES <= 1);

  logic [6:0] seg_sync [SYNC_STAGES];
  logic [3:0] an_sync  [SYNC_STAGES];
  logic [6:0] seg_s;
  logic [3:0] an_s;

  logic       an_ok;
  logic [1:0] an_idx;
  logic       same;

  state_t     state, state_next;
  logic [6:0] ref_seg;
  logic [3:0] ref_an;
  logic [7:0] count, count_next;
  logic       load_ref;
  logic       latch_fire;

  logic [3:0] dec_code;
  logic       dec_valid;
  logic       dec_blank;

  // Input synchronizer chains; idle display (all lines high) after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= '1;
        an_sync[i]  <= '1;
      end
    end else begin
      seg_sync[0] <= seg_in;
      an_sync[0]  <= an_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        seg_sync[i] <= seg_sync[i-1];
        an_sync[i]  <= an_sync[i-1];
      end
    end
  end

  assign seg_s = seg_sync[SYNC_STAGES-1];
  assign an_s  = an_sync[SYNC_STAGES-1];

  // Exactly one low anode selects a digit; anything else means no digit active
  always_comb begin
    an_ok  = 1'b1;
    an_idx = 2'd0;
    unique case (an_s)
      4'b1110: an_idx = 2'd0;
      4'b1101: an_idx = 2'd1;
      4'b1011: an_idx = 2'd2;
      4'b0111: an_idx = 2'd3;
      default: an_ok  = 1'b0;
    endcase
  end

  assign same = (seg_s == ref_seg) && (an_s == ref_an);

  // Segment pattern to code; the latched sample always equals the current
  // synchronized sample, so decoding seg_s directly is equivalent to the reference
  always_comb begin
    dec_code  = 4'hE;
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    case (seg_s)
      7'b0000001: dec_code = 4'd0;
      7'b1001111: dec_code = 4'd1;
      7'b0010010: dec_code = 4'd2;
      7'b0000110: dec_code = 4'd3;
      7'b1001100: dec_code = 4'd4;
      7'b0100100: dec_code = 4'd5;
      7'b0100000: dec_code = 4'd6;
      7'b0001111: dec_code = 4'd7;
      7'b0000000: dec_code = 4'd8;
      7'b0000100: dec_code = 4'd9;
      7'b0001000: dec_code = 4'd10;
      7'b1111111: begin
        dec_code  = 4'hF;
        dec_blank = 1'b1;
      end
      default: begin
        dec_code  = 4'hE;
        dec_valid = 1'b0;
      end
    endcase
  end

  // Stability tracker next-state logic
  always_comb begin
    state_next = state;
    count_next = count;
    load_ref   = 1'b0;
    case (state)
      IDLE: begin
        count_next = '0;
        if (an_ok) begin
          load_ref   = 1'b1;
          count_next = 8'd1;
          state_next = SINGLE_SHOT ? LATCH : TRACK;
        end
      end
      TRACK: begin
        if (!an_ok) begin
          count_next = '0;
          state_next = IDLE;
        end else if (same) begin
          count_next = count + 8'd1;
          if (count_next >= STABLE_LIMIT) state_next = LATCH;
        end else begin
          load_ref   = 1'b1;
          count_next = 8'd1;
          state_next = SINGLE_SHOT ? LATCH : TRACK;
        end
      end
      LATCH: begin
        state_next = HOLD;
      end
      HOLD: begin
        if (!an_ok) begin
          count_next = '0;
          state_next = IDLE;
        end else if (!same) begin
          load_ref   = 1'b1;
          count_next = 8'd1;
          state_next = SINGLE_SHOT ? LATCH : TRACK;
        end
      end
      default: begin
        count_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered on the edge entering LATCH, so they are visible
  // for exactly the cycle spent in LATCH
  assign latch_fire = (state_next == LATCH);

  // State, reference sample and stability counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      count   <= '0;
      ref_seg <= '1;
      ref_an  <= '1;
    end else begin
      state <= state_next;
      count <= count_next;
      if (load_ref) begin
        ref_seg <= seg_s;
        ref_an  <= an_s;
      end
    end
  end

  // Per-digit storage and latch event pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits      <= '0;
      valid       <= '0;
      blank       <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      pattern_err <= 1'b0;
    end else begin
      update      <= latch_fire;
      pattern_err <= latch_fire && !dec_valid;
      if (latch_fire) begin
        digits[{an_idx, 2'b00} +: 4] <= dec_code;
        valid[an_idx]                <= dec_valid;
        blank[an_idx]                <= dec_blank;
        update_idx                   <= an_idx;
      end
    end
  end

`ifdef SEVEN_SEG_CAPTURE_ERRCNT_EN
  // Saturating count of unknown patterns, stepped alongside each pattern_err pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (latch_fire && !dec_valid && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the seven-segment decoder. It watches a multiplexed, active-low seg/an bus, waits for each pattern to settle, and decodes the pattern back to a 4-bit code.
- It holds one code per digit position.
- Used as an on-chip readback monitor: the step generator self-checks what the display actually shows, and benches use it as a scoreboard source.

Parameters:
- STABLE_CYCLES, 4, number of consecutive identical synchronized samples (same an and seg) required before latching; legal 1..255.
- SYNC_STAGES, 2, flip-flop depth of the input synchronizer on seg_in and an_in; legal 2..4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- seg_in  input  7  observed segment lines, active-low, bit6=a ... bit0=g
- an_in  input  4  observed anode lines, active-low, an_in[0] = rightmost digit
- digits  output  16  latched codes, digits[4k+3:4k] = digit k
- valid  output  4  valid[k]=1 once digit k has latched a legal pattern
- blank  output  4  blank[k]=1 when digit k last latched 7'b1111111
- update  output  1  one-cycle pulse on every latch event
- update_idx  output  2  digit index of the latest latch; valid while update=1, held afterwards
- pattern_err  output  1  one-cycle pulse when an unknown pattern is latched
- err_count  output  8  saturating count of pattern errors (see Optional Feature)

Behaviour:
- Reset (async, active-high):
  - digits=0, valid=0, blank=0, update=0, update_idx=0, pattern_err=0, err_count=0.
  - Synchronizer flops reset to all-ones (display idle). FSM goes to IDLE and the stability counter is cleared.
- Synchronizer: seg_in and an_in each pass through SYNC_STAGES flops. All further logic uses the synchronized values seg_s and an_s.
- One-hot anode check: an_s is legal only if exactly one bit is 0, which gives index k. Zero or multiple low bits means no digit is active.
- FSM:
  - IDLE: wait for a legal an_s. When one appears, capture (an_s, seg_s) as the reference sample, set count=1 and go to TRACK. If STABLE_CYCLES=1, go directly to LATCH.
  - TRACK: sample equal to reference → count+1, and on reaching STABLE_CYCLES go to LATCH. Sample differs but is legal → reload the reference, set count=1 and stay. Illegal an_s → IDLE.
  - LATCH (one cycle): write digit k, assert update for this cycle only, set update_idx=k, go to HOLD.
  - HOLD: stay while the sample equals the reference (no relatch). Differing legal sample → reload the reference, count=1, go to TRACK. Illegal an_s → IDLE.
- Decode table (active-low) written into digit k at LATCH:

  | Pattern  | Code | valid[k] | blank[k] |
  |----------|------|----------|----------|
  | 0000001  | 0    | 1        | 0        |
  | 1001111  | 1    | 1        | 0        |
  | 0010010  | 2    | 1        | 0        |
  | 0000110  | 3    | 1        | 0        |
  | 1001100  | 4    | 1        | 0        |
  | 0100100  | 5    | 1        | 0        |
  | 0100000  | 6    | 1        | 0        |
  | 0001111  | 7    | 1        | 0        |
  | 0000000  | 8    | 1        | 0        |
  | 0000100  | 9    | 1        | 0        |
  | 0001000  | 10   | 1        | 0        |
  | 1111111  | 15   | 1        | 1        |
  | any other | 4'hE | 0       | 0        |

  Any other pattern also pulses pattern_err in the LATCH cycle.
- Latency: update goes high exactly SYNC_STAGES+STABLE_CYCLES clock edges after the first edge that samples a new, then-stable seg_in/an_in pair. With defaults this is 6 cycles.
- Only digit k is written in a latch; the other digits keep their values.
- Timing details:
  - The counter is 8 bits and never wraps; HOLD prevents counting past STABLE_CYCLES.
  - Changes on seg and an in the same cycle count as one differing sample.
  - A glitch shorter than STABLE_CYCLES synchronized cycles never latches.
- Reset asserted mid-TRACK or in LATCH aborts the latch: no update pulse, and all outputs go to their reset values immediately.

Optional Feature:
- Macro SEVEN_SEG_CAPTURE_ERRCNT_EN.
- Defined: err_count increments on every pattern_err pulse, saturates at 8'hFF and is cleared only by reset.
- Undefined: no counter logic; err_count is tied to 8'h00. Every other behaviour is identical.

Test Plan:
- After reset, drive an_in=4'b1110, seg_in=7'b0010010 and hold → update pulses once, 6 cycles later; update_idx=0, digits[3:0]=2, valid=4'b0001, blank=0; no further pulses while held.
- Scan all 4 digits with 1,2,3,4 (an 1110/1101/1011/0111), 20 cycles per digit → digits=16'h4321, valid=4'hF, 4 update pulses with update_idx 0,1,2,3.
- Glitch: stable 7 on digit 1, then seg_in=7'b0000000 for 3 cycles, then back to 7 → no update for 8; digits[7:4] stays 7; pattern_err stays 0.
- Blank plus illegal: seg_in=7'b1111111 on digit 2 → digits[11:8]=4'hF, blank[2]=1. Then seg_in=7'b1010101 → pattern_err pulses, digits[11:8]=4'hE, valid[2]=0; with the macro defined, err_count=1.
- Anode faults: an_in=4'b1111, then 4'b1100 with any seg for 30 cycles → no update, outputs unchanged.
- Reset mid-TRACK: hold a new value 3 cycles into TRACK, then assert reset → all outputs 0 immediately, no update pulse. After release, holding the value gives the latch 6 cycles later.
